// File: rtl/dsp_operand_feeder_if.sv
// Upstream operand-pair stream into the DSP operand feeder (valid/ready handshake).
interface dsp_operand_feeder_if #(
  parameter int unsigned WIDTH = 18
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/dsp_operand_feeder.sv
// Buffers A/B operand pairs, issues them to the DSP48A1 A/B register stages and
// tracks each issued pair through the M/P pipeline to flag P_in as a valid result.
module dsp_operand_feeder #(
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  dsp_operand_feeder_if.slave      up,
  input  logic                     hold,
  output logic [WIDTH-1:0]         A_out,
  output logic [WIDTH-1:0]         B_out,
  output logic                     CEA,
  output logic                     CEB,
  output logic                     CE_PIPE,
  input  logic [2*WIDTH-1:0]       P_in,
  output logic                     res_valid,
  output logic [2*WIDTH-1:0]       res_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0]   mem_a_q [DEPTH];
  logic [WIDTH-1:0]   mem_b_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [LATENCY-1:0] tag_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               issued_q;
  logic               empty, full, push, issue;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  // Reset gating keeps the handshake and status quiet while RST is held.
  assign up.in_ready = !full && !RST;
  assign push  = up.in_valid && up.in_ready;
  assign issue = !empty && !hold;

  always_comb begin
    count_d = count_q;
    unique case ({push, issue})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= up.in_a;
      mem_b_q[wr_ptr_q] <= up.in_b;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
      issued_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        a_q      <= mem_a_q[rd_ptr_q];
        b_q      <= mem_b_q[rd_ptr_q];
      end
      issued_q <= issue;
      count_q  <= count_d;
      // Tokens move only when the M/P stages advance.
      if (!hold) begin
        tag_q <= (tag_q << 1) | LATENCY'(issue);
      end
    end
  end

  assign A_out     = a_q;
  assign B_out     = b_q;
  assign CEA       = issued_q;
  assign CEB       = issued_q;
  assign CE_PIPE   = !hold;
  assign res_valid = tag_q[LATENCY-1] && !hold && !RST;
  assign res_data  = P_in;
  assign count     = count_q;
  assign busy      = (!empty || (|tag_q) || issued_q) && !RST;

endmodule
